// File: rtl/test_pulse_encoder_pkg.sv
// -----------------------------------------------------------------------------
// test_pulse_pkg
// Shared definitions for the test-pulse encoder and its consumer.
//   - FSM state encoding (3 bits) as localparams plus the enum built on them
//   - press-count code width and saturation value
//   - scenario codes 1..9, numbered to match the control unit's test states
//   - max3() helper used to size the shared timer
// Optional build macro (used by debounce_filter): TEST_PULSE_DEBOUNCE_EN
// -----------------------------------------------------------------------------
package test_pulse_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HOLD  = 3'd1;
  localparam logic [2:0] S_ARMED = 3'd2;
  localparam logic [2:0] S_COUNT = 3'd3;
  localparam logic [2:0] S_EMIT  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = S_IDLE,
    ST_HOLD  = S_HOLD,
    ST_ARMED = S_ARMED,
    ST_COUNT = S_COUNT,
    ST_EMIT  = S_EMIT
  } state_t;

  localparam int             CODE_W   = 4;
  localparam logic [CODE_W-1:0] CODE_MAX = 4'd15;

  // Scenario codes understood by the control unit; 10..15 are passed
  // through by the encoder and ignored downstream.
  typedef enum logic [CODE_W-1:0] {
    TC_NONE  = 4'd0,
    TC_SCN_1 = 4'd1,
    TC_SCN_2 = 4'd2,
    TC_SCN_3 = 4'd3,
    TC_SCN_4 = 4'd4,
    TC_SCN_5 = 4'd5,
    TC_SCN_6 = 4'd6,
    TC_SCN_7 = 4'd7,
    TC_SCN_8 = 4'd8,
    TC_SCN_9 = 4'd9
  } test_code_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/test_pulse_encoder_if.sv
// -----------------------------------------------------------------------------
// test_pulse_encoder_if
// Button-in / test-request-out bundle of the test-pulse encoder.
//   btn_raw    : raw push-button, active-high, asynchronous to clk
//   test_req   : one-cycle pulse when test mode is armed
//   armed      : level, high while armed or counting presses
//   pulse_code : last emitted press count, held until next emission
//   code_valid : one-cycle strobe, pulse_code updated this cycle
// Modports: master drives the button and observes results; slave is the
// encoder itself.
// -----------------------------------------------------------------------------
interface test_pulse_encoder_if;
  import test_pulse_pkg::*;

  logic              btn_raw;
  logic              test_req;
  logic              armed;
  logic [CODE_W-1:0] pulse_code;
  logic              code_valid;

  modport master (
    output btn_raw,
    input  test_req,
    input  armed,
    input  pulse_code,
    input  code_valid
  );

  modport slave (
    input  btn_raw,
    output test_req,
    output armed,
    output pulse_code,
    output code_valid
  );

endinterface

// File: rtl/test_pulse_encoder_debounce_filter.sv
// -----------------------------------------------------------------------------
// debounce_filter
// Two-flop synchroniser followed by a stable-count filter. Reusable for any
// board push-button.
// Build macro: TEST_PULSE_DEBOUNCE_EN
//   defined   : o_btn_db changes only after DEBOUNCE_CYCLES consecutive
//               synchronised samples that differ from the current level
//   undefined : o_btn_db is the synchroniser output (no filter delay)
// Ports:
//   clk       : system clock
//   rst       : asynchronous active-low reset
//   i_btn_raw : raw button level, asynchronous to clk
//   o_btn_db  : conditioned button level
// -----------------------------------------------------------------------------
module debounce_filter #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn_raw,
  output logic o_btn_db
);

  logic r_sync1;
  logic r_sync2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  if (DEBOUNCE_CYCLES < 1) begin : g_param_check
    $error("debounce_filter: DEBOUNCE_CYCLES must be at least 1");
  end

`ifdef TEST_PULSE_DEBOUNCE_EN
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_db;

  // r_cnt counts consecutive samples that disagree with the current level;
  // any agreeing sample restarts the run.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      r_db  <= 1'b0;
    end else if (r_sync2 == r_db) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_db  <= r_sync2;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_btn_db = r_db;
`else
  assign o_btn_db = r_sync2;
`endif

endmodule

// File: rtl/test_pulse_encoder.sv
// -----------------------------------------------------------------------------
// test_pulse_encoder
// Long press on a single button arms test mode; subsequent short presses are
// counted and, after a quiet window, the count is emitted as a 4-bit code
// with a one-cycle valid strobe.
// Build macro: TEST_PULSE_DEBOUNCE_EN (selects the debounce filter inside
// debounce_filter; undefined = synchroniser only).
// Ports:
//   clk : system clock
//   rst : asynchronous active-low reset
//   bus : test_pulse_encoder_if.slave
//         btn_raw in; test_req, armed, pulse_code, code_valid out
//
// state   | meaning
// IDLE    | waiting for a press
// HOLD    | button held, timing towards a long press
// ARMED   | test mode armed, waiting for the first counting press
// COUNT   | counting short presses, quiet window running
// EMIT    | one cycle: code presented, count cleared
// -----------------------------------------------------------------------------
module test_pulse_encoder
  import test_pulse_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 50000,
  parameter int LONG_PRESS_CYCLES = 100000000,
  parameter int WINDOW_CYCLES     = 25000000,
  parameter int ARM_TIMEOUT       = 250000000
) (
  input logic                 clk,
  input logic                 rst,
  test_pulse_encoder_if.slave bus
);

  localparam int TMR_MAX = max3(LONG_PRESS_CYCLES, WINDOW_CYCLES, ARM_TIMEOUT);
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [TMR_W-1:0] HOLD_PRE  = TMR_W'(LONG_PRESS_CYCLES - 2);
  localparam logic [TMR_W-1:0] WIN_LAST  = TMR_W'(WINDOW_CYCLES - 1);
  localparam logic [TMR_W-1:0] ARM_LAST  = TMR_W'(ARM_TIMEOUT - 1);

  if (LONG_PRESS_CYCLES < 2 || WINDOW_CYCLES < 1 || ARM_TIMEOUT < 1) begin : g_param_check
    $error("test_pulse_encoder: timing parameters out of range");
  end

  logic              w_btn_db;
  logic              r_db_d;
  logic              w_press;
  logic              w_release;

  state_t            r_state;
  state_t            w_next;
  logic [TMR_W-1:0]  r_timer;
  logic              w_tmr_clr;
  logic [CODE_W-1:0] r_count;
  logic [CODE_W-1:0] w_count_next;
  logic              w_fire_req;
  logic              w_emit_code;

  logic              r_test_req;
  logic              r_armed;
  logic [CODE_W-1:0] r_pulse_code;
  logic              r_code_valid;

  debounce_filter #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk       (clk),
    .rst       (rst),
    .i_btn_raw (bus.btn_raw),
    .o_btn_db  (w_btn_db)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_db_d <= 1'b0;
    end else begin
      r_db_d <= w_btn_db;
    end
  end

  assign w_press   =  w_btn_db & ~r_db_d;
  assign w_release = ~w_btn_db &  r_db_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_count_next = r_count;
    w_fire_req   = 1'b0;
    w_emit_code  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_press) w_next = ST_HOLD;
      end
      ST_HOLD: begin
        // test_req is registered, so it is launched one count early to be
        // high in the cycle the timer reaches its last value.
        if (r_timer == HOLD_LAST) begin
          w_next = ST_ARMED;
        end else if (w_release) begin
          w_next = ST_IDLE;
        end else if (r_timer == HOLD_PRE) begin
          w_fire_req = 1'b1;
        end
      end
      ST_ARMED: begin
        if (w_press) begin
          w_next       = ST_COUNT;
          w_count_next = {{(CODE_W-1){1'b0}}, 1'b1};
        end else if (r_timer == ARM_LAST) begin
          w_next = ST_IDLE;
        end
      end
      ST_COUNT: begin
        if (w_press) begin
          w_count_next = (r_count == CODE_MAX) ? CODE_MAX : r_count + 1'b1;
        end else if (r_timer == WIN_LAST) begin
          w_next      = ST_EMIT;
          w_emit_code = 1'b1;
        end
      end
      ST_EMIT: begin
        w_next       = ST_IDLE;
        w_count_next = '0;
      end
      default: begin
        w_next       = ST_IDLE;
        w_count_next = '0;
      end
    endcase
  end

  assign w_tmr_clr = (w_next != r_state) || w_press;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_timer <= '0;
    end else if (w_tmr_clr) begin
      r_timer <= '0;
    end else if (r_state == ST_HOLD || r_state == ST_ARMED || r_state == ST_COUNT) begin
      r_timer <= r_timer + 1'b1;
    end
  end

  // Code and strobe are loaded on the edge entering EMIT so that code_valid
  // is high for exactly the EMIT cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count      <= '0;
      r_test_req   <= 1'b0;
      r_armed      <= 1'b0;
      r_pulse_code <= '0;
      r_code_valid <= 1'b0;
    end else begin
      r_count      <= w_count_next;
      r_test_req   <= w_fire_req;
      r_armed      <= (w_next == ST_ARMED) || (w_next == ST_COUNT);
      r_code_valid <= w_emit_code;
      if (w_emit_code) r_pulse_code <= r_count;
    end
  end

  assign bus.test_req   = r_test_req;
  assign bus.armed      = r_armed;
  assign bus.pulse_code = r_pulse_code;
  assign bus.code_valid = r_code_valid;

endmodule

// File: tb/tb_test_pulse_encoder.sv
module tb_test_pulse_encoder;
  import test_pulse_pkg::*;

  localparam int DEB  = 4;
  localparam int LP   = 20;
  localparam int WIN  = 10;
  localparam int ATO  = 30;
`ifdef TEST_PULSE_DEBOUNCE_EN
  localparam int DLY  = 2 + DEB;
`else
  localparam int DLY  = 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;

  test_pulse_encoder_if tb_if ();

  test_pulse_encoder #(
    .DEBOUNCE_CYCLES   (DEB),
    .LONG_PRESS_CYCLES (LP),
    .WINDOW_CYCLES     (WIN),
    .ARM_TIMEOUT       (ATO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (tb_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor: records strobes and catches pulse_code changing outside
  // a code_valid cycle.
  int          tr_cnt  = 0;
  int          cv_cnt  = 0;
  int          tr_cyc  = -1;
  int          cv_cyc  = -1;
  int          bad_chg = 0;
  logic [3:0]  cv_code = '0;
  logic [3:0]  prev_code = '0;

  always @(negedge clk) begin
    if (rst) begin
      if (tb_if.test_req === 1'b1) begin
        tr_cnt = tr_cnt + 1;
        tr_cyc = cyc;
      end
      if (tb_if.code_valid === 1'b1) begin
        cv_cnt  = cv_cnt + 1;
        cv_cyc  = cyc;
        cv_code = tb_if.pulse_code;
      end else if (tb_if.pulse_code !== prev_code) begin
        bad_chg = bad_chg + 1;
      end
    end
    prev_code = tb_if.pulse_code;
  end

  int n_assert = 0;
  int n_fail   = 0;
  int last_code = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int sat_code(input int n);
    return (n > int'(CODE_MAX)) ? int'(CODE_MAX) : n;
  endfunction

  logic [31:0] outs_w;
  always_comb outs_w = {25'd0, tb_if.test_req, tb_if.armed, tb_if.code_valid, tb_if.pulse_code};

  // Long press then release; r_arm is the cycle the raw level rose.
  task automatic arm(output int r_arm);
    int h, g;
    h = $urandom_range(25, 30);
    g = $urandom_range(8, 12);
    r_arm = cyc;
    tb_if.btn_raw = 1'b1;
    tick(h);
    tb_if.btn_raw = 1'b0;
    tick(g);
  endtask

  // n clean presses spaced no more than WIN cycles apart.
  task automatic presses(input int n, output int r_last);
    int hp, lp;
    r_last = cyc;
    for (int i = 0; i < n; i++) begin
      hp = $urandom_range(5, 6);
      lp = $urandom_range(4, WIN - hp);
      r_last = cyc;
      tb_if.btn_raw = 1'b1;
      tick(hp);
      tb_if.btn_raw = 1'b0;
      tick(lp);
    end
  endtask

  task automatic full_sequence(input int n);
    int r_arm, r_last, b_tr, b_cv;
    b_tr = tr_cnt;
    b_cv = cv_cnt;
    arm(r_arm);
    chk("treq_count", tr_cnt - b_tr, 1);
    chk("treq_latency", tr_cyc, r_arm + DLY + LP);
    chk("armed_after_arm", tb_if.armed, 1);
    presses(n, r_last);
    chk("armed_in_window", tb_if.armed, 1);
    chk("no_early_code", cv_cnt - b_cv, 0);
    tick(WIN + DLY + 4);
    chk("code_valid_count", cv_cnt - b_cv, 1);
    chk("code_valid_latency", cv_cyc, r_last + DLY + WIN + 1);
    chk("emitted_code", cv_code, sat_code(n));
    chk("pulse_code_held", tb_if.pulse_code, sat_code(n));
    chk("armed_after_emit", tb_if.armed, 0);
    chk("single_treq", tr_cnt - b_tr, 1);
    last_code = sat_code(n);
  endtask

  initial begin
    int r_arm, r_last, b_tr, b_cv, a_entry, k;
    tb_if.btn_raw = 1'b0;

    // Reset held with the button toggling, then idle after release.
    for (int i = 0; i < 8; i++) begin
      tb_if.btn_raw = 1'($urandom_range(0, 1));
      tick(1);
      chk("outs_in_reset", outs_w, 0);
    end
    tb_if.btn_raw = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("outs_idle", outs_w, 0);
    end

    // Three presses.
    full_sequence(3);

    // Short hold from IDLE: nothing happens.
    b_tr = tr_cnt;
    b_cv = cv_cnt;
    tb_if.btn_raw = 1'b1;
    tick(10);
    tb_if.btn_raw = 1'b0;
    tick(40);
    chk("short_hold_treq", tr_cnt - b_tr, 0);
    chk("short_hold_code", cv_cnt - b_cv, 0);
    chk("short_hold_armed", tb_if.armed, 0);

    // Arm timeout (with glitches when the filter is present).
    b_tr = tr_cnt;
    b_cv = cv_cnt;
    arm(r_arm);
    a_entry = r_arm + DLY + LP + 1;
`ifdef TEST_PULSE_DEBOUNCE_EN
    repeat (2) begin
      tb_if.btn_raw = 1'b1;
      tick(2);
      tb_if.btn_raw = 1'b0;
      tick(3);
    end
`endif
    k = 0;
    while (cyc < a_entry + ATO - 1 && k < 500) begin
      tick(1);
      k++;
    end
    chk("timeout_wait_sync", cyc, a_entry + ATO - 1);
    chk("armed_before_timeout", tb_if.armed, 1);
    tick(1);
    chk("armed_after_timeout", tb_if.armed, 0);
    tick(20);
    chk("timeout_treq", tr_cnt - b_tr, 1);
    chk("timeout_no_code", cv_cnt - b_cv, 0);
    chk("timeout_code_kept", tb_if.pulse_code, last_code);

    // Saturation.
    full_sequence(17);

    // Reset mid-window aborts without a code.
    b_cv = cv_cnt;
    arm(r_arm);
    presses(2, r_last);
    rst = 1'b0;
    tick(3);
    chk("outs_mid_reset", outs_w, 0);
    rst = 1'b1;
    tick(WIN + DLY + 10);
    chk("abort_no_code", cv_cnt - b_cv, 0);
    chk("abort_code_zero", tb_if.pulse_code, 0);
    chk("abort_armed", tb_if.armed, 0);
    last_code = 0;
    full_sequence(int'($urandom_range(1, 9)));

    // Random press counts across the full range.
    for (int i = 0; i < 3; i++) begin
      full_sequence(int'($urandom_range(1, 17)));
    end

    chk("code_stable_outside_strobe", bad_chg, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
